imm_decode_stage: RTL

//  Pipelined, parametrised immediate generator for the decode stage. Accepts {inst, pc} over a

---
 rtl/imm_decode_stage_pkg.sv | 26 ++
 rtl/imm_decode_core.sv | 59 +++++
 rtl/imm_decode_stage.sv | 114 +++++++++++
 3 files changed

// File: rtl/imm_decode_stage_pkg.sv
// rtl/imm_decode_stage_pkg.sv - opcode and immediate-format constants shared by the decode stage
package imm_decode_stage_pkg;

    typedef logic [2:0] fmt_t;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam fmt_t FMT_I     = 3'd0;
    localparam fmt_t FMT_S     = 3'd1;
    localparam fmt_t FMT_B     = 3'd2;
    localparam fmt_t FMT_U     = 3'd3;
    localparam fmt_t FMT_J     = 3'd4;
    localparam fmt_t FMT_SHAMT = 3'd5;
    localparam fmt_t FMT_NONE  = 3'd7;

endpackage

// File: rtl/imm_decode_core.sv
// rtl/imm_decode_core.sv - combinational RV32I immediate extractor
// Maps an instruction word to its sign/zero-extended immediate, format code and illegal flag.
module imm_decode_core
    import imm_decode_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst_i,
    output logic [XLEN-1:0] imm_o,
    output fmt_t            fmt_o,
    output logic            illegal_o
);

    always_comb begin
        imm_o     = '0;
        fmt_o     = FMT_NONE;
        illegal_o = 1'b0;
        case (inst_i[6:0])
            OPC_LOAD, OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM: begin
                imm_o = XLEN'($signed(inst_i[31:20]));
                fmt_o = FMT_I;
            end
            OPC_OP_IMM: begin
                // Shifts carry funct7 in the upper bits, so only the shamt field is kept
                if (inst_i[14:12] == 3'b001 || inst_i[14:12] == 3'b101) begin
                    if (XLEN == 64) imm_o = XLEN'(inst_i[25:20]);
                    else            imm_o = XLEN'(inst_i[24:20]);
                    fmt_o = FMT_SHAMT;
                end else begin
                    imm_o = XLEN'($signed(inst_i[31:20]));
                    fmt_o = FMT_I;
                end
            end
            OPC_STORE: begin
                imm_o = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
                fmt_o = FMT_S;
            end
            OPC_BRANCH: begin
                imm_o = XLEN'($signed({inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0}));
                fmt_o = FMT_B;
            end
            OPC_LUI, OPC_AUIPC: begin
                imm_o = XLEN'($signed({inst_i[31:12], 12'b0}));
                fmt_o = FMT_U;
            end
            OPC_JAL: begin
                imm_o = XLEN'($signed({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0}));
                fmt_o = FMT_J;
            end
            OPC_OP: begin
                fmt_o = FMT_NONE;
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_decode_stage.sv
// rtl/imm_decode_stage.sv - pipelined immediate decode stage with 2-entry skid buffer
// Decodes on the way in; a main register feeds the outputs and a skid register absorbs one stalled beat.
module imm_decode_stage
    import imm_decode_stage_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit EN_TARGET = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal,
    output logic [XLEN-1:0] out_target
);

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        fmt_t            fmt;
        logic            illegal;
        logic [XLEN-1:0] target;
    } beat_t;

    logic [XLEN-1:0] dec_imm;
    fmt_t            dec_fmt;
    logic            dec_illegal;
    logic [XLEN-1:0] dec_target;
    beat_t           new_beat;

    beat_t main_q, main_d, skid_q, skid_d;
    logic  main_valid_q, main_valid_d;
    logic  skid_valid_q, skid_valid_d;
    logic  in_ready_q;
    logic  accept;

    imm_decode_core #(.XLEN(XLEN)) u_core (
        .inst_i    (in_inst),
        .imm_o     (dec_imm),
        .fmt_o     (dec_fmt),
        .illegal_o (dec_illegal)
    );

    generate
        if (EN_TARGET) begin : g_target
            assign dec_target = in_pc + dec_imm;
        end else begin : g_no_target
            assign dec_target = '0;
        end
    endgenerate

    assign new_beat = '{inst: in_inst, pc: in_pc, imm: dec_imm, fmt: dec_fmt,
                        illegal: dec_illegal, target: dec_target};
    assign accept   = in_valid && in_ready_q;

    // in_ready_q is low whenever skid holds a beat, so accept never coincides with skid draining
    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (skid_valid_q) begin
            if (out_ready) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!main_valid_q || out_ready) begin
                main_d       = new_beat;
                main_valid_d = 1'b1;
            end else begin
                skid_d       = new_beat;
                skid_valid_d = 1'b1;
            end
        end else if (main_valid_q && out_ready) begin
            main_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= !skid_valid_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = main_valid_q;
    assign out_inst    = main_q.inst;
    assign out_pc      = main_q.pc;
    assign out_imm     = main_q.imm;
    assign out_fmt     = main_q.fmt;
    assign out_illegal = main_q.illegal;
    assign out_target  = main_q.target;

endmodule
